heartbeat_pwm: RTL

//  Downstream consumer of the divided tick from the clock divider. Every rising edge
//  of that tick advances a heartbeat envelope (strong beat, gap, weak beat, rest).
//  The envelope becomes an LED PWM waveform at the system clock (12 MHz).
//  The divider's period select sets the beat speed. This block adds no clock domain:

---
 rtl/heartbeat_pwm_if.sv | 22 ++
 rtl/heartbeat_pwm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/heartbeat_pwm_if.sv
// rtl/heartbeat_pwm_if.sv - tick/enable inputs and LED/duty/debug outputs of heartbeat_pwm
`timescale 1ns/1ps
interface heartbeat_pwm_if #(
  parameter int PWM_BITS = 8
) ();
  logic                tick_in;
  logic                enable;
  logic                led_out;
  logic [PWM_BITS-1:0] duty_out;
  logic                beat_start;
  logic [2:0]          state_out;

  modport master (
    output tick_in, enable,
    input  led_out, duty_out, beat_start, state_out
  );

  modport slave (
    input  tick_in, enable,
    output led_out, duty_out, beat_start, state_out
  );
endinterface

// File: rtl/heartbeat_pwm.sv
// rtl/heartbeat_pwm.sv - tick-driven heartbeat envelope rendered as a glitch-free LED PWM
`timescale 1ns/1ps
module heartbeat_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 32,
  parameter int PEAK1      = 255,
  parameter int PEAK2      = 160,
  parameter int GAP_TICKS  = 6,
  parameter int REST_TICKS = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  heartbeat_pwm_if.slave  hb
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RISE1 = 3'd1,
    FALL1 = 3'd2,
    GAP   = 3'd3,
    RISE2 = 3'd4,
    FALL2 = 3'd5,
    REST  = 3'd6
  } state_t;

  localparam int CNT_MAX = (GAP_TICKS > REST_TICKS) ? GAP_TICKS : REST_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Ramp arithmetic runs one bit wider than the duty so overflow/underflow is visible.
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS-1:0] PEAK1_W  = PWM_BITS'(PEAK1);
  localparam logic [PWM_BITS-1:0] PEAK2_W  = PWM_BITS'(PEAK2);
  localparam logic [CNT_W-1:0]    GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]    REST_LAST = CNT_W'(REST_TICKS - 1);

  state_t              state_q, state_d;
  logic                tick_d_q;
  logic [PWM_BITS-1:0] duty_reg_q, duty_reg_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                led_q, led_d;
  logic                beat_start_q, beat_start_d;

  logic                tick_rise;
  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS:0]   diff;
  logic [PWM_BITS-1:0] peak;

  // Envelope sequencer: advances one step per tick rising edge; enable low overrides everything.
  always_comb begin
    tick_rise    = hb.tick_in & ~tick_d_q;
    sum          = {1'b0, duty_reg_q} + STEP_W;
    diff         = {1'b0, duty_reg_q} - STEP_W;
    peak         = (state_q == RISE2) ? PEAK2_W : PEAK1_W;
    state_d      = state_q;
    duty_reg_d   = duty_reg_q;
    cnt_d        = cnt_q;
    beat_start_d = 1'b0;

    if (!hb.enable) begin
      state_d    = IDLE;
      duty_reg_d = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = RISE1;
          duty_reg_d   = '0;
          cnt_d        = '0;
          beat_start_d = 1'b1;
        end
        RISE1, RISE2: begin
          if (tick_rise) begin
            if (sum >= {1'b0, peak}) begin
              duty_reg_d = peak;
              state_d    = (state_q == RISE1) ? FALL1 : FALL2;
            end else begin
              duty_reg_d = sum[PWM_BITS-1:0];
            end
          end
        end
        FALL1, FALL2: begin
          if (tick_rise) begin
            // A set top bit means the subtraction borrowed: clamp to zero.
            if (diff[PWM_BITS] || (diff == '0)) begin
              duty_reg_d = '0;
              cnt_d      = '0;
              state_d    = (state_q == FALL1) ? GAP : REST;
            end else begin
              duty_reg_d = diff[PWM_BITS-1:0];
            end
          end
        end
        GAP: begin
          if (tick_rise) begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              state_d = RISE2;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        REST: begin
          if (tick_rise) begin
            if (cnt_q == REST_LAST) begin
              cnt_d        = '0;
              state_d      = RISE1;
              beat_start_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d    = IDLE;
          duty_reg_d = '0;
          cnt_d      = '0;
        end
      endcase
    end
  end

  // PWM datapath: duty is latched only at the period boundary so a window never glitches.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    duty_act_d = duty_act_q;
    led_d      = 1'b0;
    if (!hb.enable) begin
      duty_act_d = '0;
    end else begin
      if (&pwm_cnt_q) begin
        duty_act_d = duty_reg_q;
      end
      led_d = (pwm_cnt_q < duty_act_q);
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_d_q     <= 1'b0;
      duty_reg_q   <= '0;
      duty_act_q   <= '0;
      pwm_cnt_q    <= '0;
      cnt_q        <= '0;
      led_q        <= 1'b0;
      beat_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_d_q     <= hb.tick_in;
      duty_reg_q   <= duty_reg_d;
      duty_act_q   <= duty_act_d;
      pwm_cnt_q    <= pwm_cnt_d;
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      beat_start_q <= beat_start_d;
    end
  end

  assign hb.led_out    = led_q;
  assign hb.duty_out   = duty_reg_q;
  assign hb.beat_start = beat_start_q;
  assign hb.state_out  = state_q;

endmodule
